// File: rtl/bram_bank_arbiter.sv
// Two-master round-robin arbiter in front of a banked BRAM.
// One access issues per cycle; responses are tracked by a fixed-latency
// shift pipeline so that read data and errors return in issue order.
module bram_bank_arbiter #(
  parameter int NUM_BANKS = 25,
  parameter int RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        bram_en,
  output logic        bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata
);

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_lat
    $error("RD_LAT must be in 1..4");
  end

  localparam logic [8:0] NB = 9'(NUM_BANKS);

  // Issue-stage registers
  logic        m0_gnt_q, m0_gnt_d;
  logic        m1_gnt_q, m1_gnt_d;
  logic        bram_en_q, bram_en_d;
  logic        bram_we_q, bram_we_d;
  logic [31:0] bram_addr_q, bram_addr_d;
  logic [31:0] bram_wdata_q, bram_wdata_d;
  // 1 = m1 was granted last
  logic        last_q, last_d;

  // Response pipeline: entry 0 is the issue cycle, entry RD_LAT the response cycle
  logic [RD_LAT:0] pv_q, pv_d;   // valid
  logic [RD_LAT:0] po_q, po_d;   // owner (1 = m1)
  logic [RD_LAT:0] pr_q, pr_d;   // is_read
  logic [RD_LAT:0] pe_q, pe_d;   // out-of-range

  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        r0, r1, win0, win1, issue, in_range, sel_we;
  logic [31:0] sel_addr, sel_wdata;

  // Arbitration, address decode and response-pipeline shift
  always_comb begin
    // a master is not re-arbitrated in the cycle its grant is visible
    r0        = m0_req & ~m0_gnt_q;
    r1        = m1_req & ~m1_gnt_q;
    win1      = r1 & (~r0 | ~last_q);
    win0      = r0 & ~win1;
    issue     = win0 | win1;
    sel_addr  = win1 ? m1_addr  : m0_addr;
    sel_we    = win1 ? m1_we    : m0_we;
    sel_wdata = win1 ? m1_wdata : m0_wdata;
    in_range  = ({1'b0, sel_addr[19:12]} < NB);

    m0_gnt_d     = win0;
    m1_gnt_d     = win1;
    bram_en_d    = issue & in_range;
    bram_we_d    = issue & in_range & sel_we;
    bram_addr_d  = (issue & in_range) ? sel_addr  : '0;
    bram_wdata_d = (issue & in_range) ? sel_wdata : '0;
    last_d       = issue ? win1 : last_q;

    pv_d = {pv_q[RD_LAT-1:0], issue};
    po_d = {po_q[RD_LAT-1:0], win1};
    pr_d = {pr_q[RD_LAT-1:0], ~sel_we};
    pe_d = {pe_q[RD_LAT-1:0], ~in_range};
  end

  // Response decode; rdata passes bram_rdata through in the rvalid cycle and holds otherwise
  always_comb begin
    m0_rvalid  = pv_q[RD_LAT] & ~po_q[RD_LAT] & pr_q[RD_LAT] & ~pe_q[RD_LAT];
    m1_rvalid  = pv_q[RD_LAT] &  po_q[RD_LAT] & pr_q[RD_LAT] & ~pe_q[RD_LAT];
    m0_err     = pv_q[RD_LAT] & ~po_q[RD_LAT] & pe_q[RD_LAT];
    m1_err     = pv_q[RD_LAT] &  po_q[RD_LAT] & pe_q[RD_LAT];
    m0_rdata   = m0_rvalid ? bram_rdata : m0_rdata_q;
    m1_rdata   = m1_rvalid ? bram_rdata : m1_rdata_q;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    m0_gnt     = m0_gnt_q;
    m1_gnt     = m1_gnt_q;
    bram_en    = bram_en_q;
    bram_we    = bram_we_q;
    bram_addr  = bram_addr_q;
    bram_wdata = bram_wdata_q;
  end

  // State registers with synchronous reset; pointer resets to "m1 last"
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      last_q       <= 1'b1;
      pv_q         <= '0;
      po_q         <= '0;
      pr_q         <= '0;
      pe_q         <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      last_q       <= last_d;
      pv_q         <= pv_d;
      po_q         <= po_d;
      pr_q         <= pr_d;
      pe_q         <= pe_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

endmodule
